// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared state encoding, counter width and timing defaults for the feeder
package feeder_pkg;

  localparam int CNT_W         = 4;
  localparam int FOOD_TIME_DEF = 10;
  localparam int COOLDOWN_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_COOL     = 2'd2
  } state_t;

endpackage

// File: rtl/window_timer.sv
// rtl/window_timer.sv - window/cooldown counter with load, enable and terminal-count flag
module window_timer
  import feeder_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // load wins over enable so a phase change always restarts from zero
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/feed_scheduler.sv
// rtl/feed_scheduler.sv - round-robin feeder scheduler: dispense window, abort and cooldown
module feed_scheduler
  import feeder_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int FOOD_TIME = FOOD_TIME_DEF,
  parameter int COOLDOWN  = COOLDOWN_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             stop,
  output logic [NREQ-1:0]  grant,
  output logic             motor_on,
  output logic             done,
  output logic [1:0]       done_id,
  output logic             busy,
  output logic [CNT_W-1:0] count_out
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(FOOD_TIME - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);

  state_t            state;
  logic [1:0]        last_grant;
  logic [1:0]        pick_idx;
  logic              pick_valid;
  logic [NREQ-1:0]   pick_onehot;
  logic [2:0]        sum;
  logic              abort;
  logic              win_tc;
  logic              tmr_load;
  logic              tmr_enable;
  logic [CNT_W-1:0]  tmr_limit;

  assign abort = stop || !(|(req & grant));

  // search starts one past the last winner and wraps modulo NREQ
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    sum         = '0;
    for (int off = 1; off <= NREQ; off++) begin
      sum = {1'b0, last_grant} + 3'(off);
      if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
      if (!pick_valid && req[sum[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = sum[1:0];
      end
    end
    pick_onehot[pick_idx] = pick_valid;
  end

  always_comb begin
    tmr_load   = 1'b1;
    tmr_enable = 1'b0;
    tmr_limit  = WIN_LAST;
    case (state)
      ST_DISPENSE: begin
        tmr_load   = abort || win_tc;
        tmr_enable = 1'b1;
      end
      ST_COOL: begin
        tmr_limit  = COOL_LAST;
        tmr_load   = win_tc;
        tmr_enable = 1'b1;
      end
      default: ;
    endcase
  end

  window_timer u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (tmr_load),
    .enable (tmr_enable),
    .limit  (tmr_limit),
    .count  (count_out),
    .tc     (win_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      motor_on   <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      busy       <= 1'b0;
      last_grant <= 2'(NREQ - 1);
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid && !stop) begin
            state      <= ST_DISPENSE;
            grant      <= pick_onehot;
            motor_on   <= 1'b1;
            busy       <= 1'b1;
            last_grant <= pick_idx;
          end
        end
        ST_DISPENSE: begin
          // an abort on the final cycle suppresses done
          if (abort || win_tc) begin
            grant    <= '0;
            motor_on <= 1'b0;
            if (!abort) begin
              done    <= 1'b1;
              done_id <= last_grant;
            end
            if (COOLDOWN == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_COOL;
            end
          end
        end
        ST_COOL: begin
          if (win_tc) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          grant    <= '0;
          motor_on <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feed_scheduler.sv
// tb/tb_feed_scheduler.sv - scoreboard bench for feed_scheduler, default and zero-cooldown builds
module tb_feed_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] req, req_z;
  logic       stop, stop_z;
  logic [2:0] grant, grant_z;
  logic       motor_on, motor_on_z, done, done_z, busy, busy_z;
  logic [1:0] done_id, done_id_z;
  logic [3:0] count_out, count_out_z;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_grant_q[$];
  logic [1:0] exp_done_q[$];

  always #5 clock = ~clock;

  feed_scheduler #(.NREQ(3), .FOOD_TIME(10), .COOLDOWN(4)) dut (
    .clock(clock), .reset(reset), .req(req), .stop(stop), .grant(grant),
    .motor_on(motor_on), .done(done), .done_id(done_id), .busy(busy), .count_out(count_out)
  );

  feed_scheduler #(.NREQ(3), .FOOD_TIME(10), .COOLDOWN(0)) dut_z (
    .clock(clock), .reset(reset), .req(req_z), .stop(stop_z), .grant(grant_z),
    .motor_on(motor_on_z), .done(done_z), .done_id(done_id_z), .busy(busy_z), .count_out(count_out_z)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_count(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (motor_on === 1'b1 && count_out === v) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; stop = 1'b0; req_z = '0; stop_z = 1'b0;
    repeat (2) tick();
    checks++;
    if ({grant, motor_on, done, done_id, busy, count_out} !== 14'd0)
      $display("FAIL reset_outputs: got %h required 0", {grant, motor_on, done, done_id, busy, count_out});
    checks++;
    if ({grant_z, motor_on_z, done_z, busy_z} !== 6'd0)
      $display("FAIL reset_outputs_z: got %h required 0", {grant_z, motor_on_z, done_z, busy_z});
    if ({grant, motor_on, done, done_id, busy, count_out} !== 14'd0) failures++;
    if ({grant_z, motor_on_z, done_z, busy_z} !== 6'd0) failures++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    logic [2:0] eg;
    logic [1:0] ed, seen_id;
    int motor_cnt, busy_cnt, done_cnt;
    req = 3'b001;
    exp_grant_q.push_back(3'b001);
    exp_done_q.push_back(2'd0);
    tick();
    eg = exp_grant_q.pop_front();
    checks++;
    if (grant !== eg) begin failures++; $display("FAIL normal_grant: got %b required %b", grant, eg); end
    motor_cnt = 0; busy_cnt = 0; done_cnt = 0; seen_id = 2'd3;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) tick();
      if (motor_on) motor_cnt++;
      if (busy) busy_cnt++;
      if (k == 9) begin
        checks++;
        if (count_out !== 4'd9) begin failures++; $display("FAIL normal_count9: got %0d required 9", count_out); end
      end
      if (done) begin done_cnt++; seen_id = done_id; req = '0; end
    end
    ed = exp_done_q.pop_front();
    checks++;
    if (motor_cnt != 10) begin failures++; $display("FAIL normal_motor_cycles: got %0d required 10", motor_cnt); end
    checks++;
    if (busy_cnt != 14) begin failures++; $display("FAIL normal_busy_cycles: got %0d required 14", busy_cnt); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL normal_done_pulses: got %0d required 1", done_cnt); end
    checks++;
    if (seen_id !== ed) begin failures++; $display("FAIL normal_done_id: got %0d required %0d", seen_id, ed); end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg, prev;
    int last_t, n;
    apply_reset();
    req = 3'b111;
    exp_grant_q.push_back(3'b001); exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100); exp_grant_q.push_back(3'b001);
    prev = '0; last_t = -1; n = 0;
    for (int t = 0; t < 80 && n < 4; t++) begin
      tick();
      checks++;
      if (motor_on !== |grant) begin failures++; $display("FAIL rr_motor_eq_grant: got %b required %b", motor_on, |grant); end
      if (grant !== 3'b000 && prev === 3'b000) begin
        eg = exp_grant_q.pop_front();
        checks++;
        if (grant !== eg) begin failures++; $display("FAIL rr_grant_%0d: got %b required %b", n, grant, eg); end
        if (last_t >= 0) begin
          checks++;
          if (t - last_t != 15) begin failures++; $display("FAIL rr_spacing_%0d: got %0d required 15", n, t - last_t); end
        end
        last_t = t;
        n++;
      end
      prev = grant;
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL rr_grant_count: got %0d required 4", n); end
    exp_grant_q.delete();
    req = '0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
  endtask

  task automatic test_withdrawal();
    logic [2:0] eg;
    bit ok;
    int cool_cnt, dn;
    apply_reset();
    req = 3'b010;
    exp_grant_q.push_back(3'b010);
    tick();
    eg = exp_grant_q.pop_front();
    checks++;
    if (grant !== eg) begin failures++; $display("FAIL wd_grant: got %b required %b", grant, eg); end
    wait_count(4'd5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wd_reach_count5: got timeout required count_out=5"); end
    req = '0;
    tick();
    checks++;
    if ({grant, motor_on, done} !== 5'd0) begin failures++; $display("FAIL wd_abort_outputs: got %b required 0", {grant, motor_on, done}); end
    checks++;
    if (busy !== 1'b1 || count_out !== 4'd0) begin failures++; $display("FAIL wd_cool_entry: got busy=%b count=%0d required busy=1 count=0", busy, count_out); end
    cool_cnt = 1; dn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dn++;
      if (!busy) break;
      cool_cnt++;
    end
    checks++;
    if (cool_cnt != 4) begin failures++; $display("FAIL wd_cool_cycles: got %0d required 4", cool_cnt); end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL wd_no_done: got %0d pulses required 0", dn); end
  endtask

  task automatic test_stop();
    logic [2:0] eg;
    bit ok, seen;
    int dn;
    apply_reset();
    stop = 1'b1; req = 3'b001; seen = 1'b0;
    repeat (5) begin tick(); if (grant !== 3'b000) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL stop_idle_block: got grant while stop high required none"); end
    stop = 1'b0;
    exp_grant_q.push_back(3'b001);
    tick();
    eg = exp_grant_q.pop_front();
    checks++;
    if (grant !== eg) begin failures++; $display("FAIL stop_release_grant: got %b required %b", grant, eg); end
    wait_count(4'd9, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stop_reach_count9: got timeout required count_out=9"); end
    stop = 1'b1;
    tick();
    checks++;
    if ({grant, motor_on, done} !== 5'd0 || busy !== 1'b1)
      begin failures++; $display("FAIL stop_completion_abort: got grant=%b motor=%b done=%b busy=%b required 000 0 0 1", grant, motor_on, done, busy); end
    stop = 1'b0; req = '0; dn = 0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin tick(); if (done) dn++; end
    checks++;
    if (dn != 0 || busy !== 1'b0) begin failures++; $display("FAIL stop_cool_tail: got done=%0d busy=%b required 0 0", dn, busy); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] eg;
    bit ok;
    req = 3'b001;
    exp_grant_q.push_back(3'b001);
    tick();
    eg = exp_grant_q.pop_front();
    checks++;
    if (grant !== eg) begin failures++; $display("FAIL rm_grant: got %b required %b", grant, eg); end
    wait_count(4'd3, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rm_reach_count3: got timeout required count_out=3"); end
    reset = 1'b0;
    tick();
    checks++;
    if ({grant, motor_on, done, done_id, busy, count_out} !== 14'd0)
      begin failures++; $display("FAIL rm_outputs_cleared: got %h required 0", {grant, motor_on, done, done_id, busy, count_out}); end
    reset = 1'b1; req = 3'b110;
    exp_grant_q.push_back(3'b010);
    tick();
    eg = exp_grant_q.pop_front();
    checks++;
    if (grant !== eg) begin failures++; $display("FAIL rm_post_reset_grant: got %b required %b", grant, eg); end
    req = '0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
  endtask

  task automatic test_cooldown0();
    logic [2:0] prev;
    int done_t[$], grant_t[$];
    apply_reset();
    req_z = 3'b001; prev = '0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (grant_z !== 3'b000 && prev === 3'b000) grant_t.push_back(t);
      if (done_z) begin
        done_t.push_back(t);
        checks++;
        if (done_id_z !== 2'd0 || busy_z !== 1'b0)
          begin failures++; $display("FAIL cz_done_state: got id=%0d busy=%b required 0 0", done_id_z, busy_z); end
      end
      prev = grant_z;
    end
    req_z = '0;
    checks++;
    if (done_t.size() < 3 || grant_t.size() < 3)
      begin failures++; $display("FAIL cz_event_count: got done=%0d grants=%0d required >=3", done_t.size(), grant_t.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (done_t[i] - done_t[i-1] != 11) begin failures++; $display("FAIL cz_done_spacing: got %0d required 11", done_t[i] - done_t[i-1]); end
        checks++;
        if (grant_t[i] - grant_t[i-1] != 11) begin failures++; $display("FAIL cz_grant_spacing: got %0d required 11", grant_t[i] - grant_t[i-1]); end
      end
    end
    repeat (12) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_round_robin();
    test_withdrawal();
    test_stop();
    test_reset_mid();
    test_cooldown0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
